// File: rtl/fsm_change_dispenser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fsm_change_dispenser                                       |
// | Description : Pays out change (credit - price, in 5-unit coins) through  |
// |               a coin hopper. Ten-coins are used first, with five-coins   |
// |               filling in when the tens run out. Each coin is requested   |
// |               with a held request that waits for hopper_ack. The block   |
// |               keeps the coin inventory and flags infeasible payouts and  |
// |               hopper timeouts.                                           |
// | Ports       : clk, reset (sync, active-high)                             |
// |               start/credit/price - payout request, taken only in IDLE    |
// |               refill             - reload inventories, only in IDLE      |
// |               hopper_ack         - hopper released the requested coin    |
// |               coin_T/coin_F      - coin requests, held until ack         |
// |               busy/done/error    - status (done/error are 1-cycle pulses)|
// |               tens_left/fives_left - current inventory                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fsm_change_dispenser #(
  parameter int W           = 6,
  parameter int INIT_TENS   = 4,
  parameter int INIT_FIVES  = 4,
  parameter int CW          = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  credit,
  input  logic [W-1:0]  price,
  input  logic          refill,
  input  logic          hopper_ack,
  output logic          coin_T,
  output logic          coin_F,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [CW-1:0] tens_left,
  output logic [CW-1:0] fives_left
);

  // Plan arithmetic is done one bit wider than the widest operand so that
  // the feasibility compare never truncates.
  localparam int PW = ((W > CW) ? W : CW) + 1;
  localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_credit;
  logic [W-1:0]   r_price;
  logic [PW-1:0]  r_n_tens;
  logic [PW-1:0]  r_n_fives;
  logic [TW-1:0]  r_timer;

  logic [PW-1:0]  w_chg;
  logic [PW-1:0]  w_half;
  logic [PW-1:0]  w_tens;
  logic [PW-1:0]  w_nt;
  logic [PW-1:0]  w_nf;
  logic           w_short;
  logic           w_nf_over;
  logic           w_timeout;

  // Payout plan: as many tens as change and inventory allow, rest in fives.
  always_comb begin
    w_short   = (r_credit < r_price);
    w_chg     = PW'(r_credit) - PW'(r_price);
    w_half    = w_chg >> 1;
    w_tens    = PW'(tens_left);
    w_nt      = (w_half < w_tens) ? w_half : w_tens;
    w_nf      = w_chg - (w_nt << 1);
    w_nf_over = (w_nf > PW'(fives_left));
    w_timeout = (r_timer == TW'(ACK_TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_credit   <= '0;
      r_price    <= '0;
      r_n_tens   <= '0;
      r_n_fives  <= '0;
      r_timer    <= '0;
      coin_T     <= 1'b0;
      coin_F     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      tens_left  <= CW'(INIT_TENS);
      fives_left <= CW'(INIT_FIVES);
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Refill lands before CHECK, so a simultaneous start sees it.
          if (refill) begin
            tens_left  <= CW'(INIT_TENS);
            fives_left <= CW'(INIT_FIVES);
          end
          if (start) begin
            r_credit <= credit;
            r_price  <= price;
            busy     <= 1'b1;
            r_state  <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (w_short || w_nf_over) begin
            error   <= 1'b1;
            r_state <= S_ERR;
          end else begin
            r_n_tens  <= w_nt;
            r_n_fives <= w_nf;
            r_state   <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          r_timer <= '0;
          if (r_n_tens != '0) begin
            coin_T  <= 1'b1;
            r_state <= S_WAIT;
          end else if (r_n_fives != '0) begin
            coin_F  <= 1'b1;
            r_state <= S_WAIT;
          end else begin
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_WAIT: begin
          if (hopper_ack) begin
            // Ack takes priority over a timeout landing in the same cycle.
            coin_T <= 1'b0;
            coin_F <= 1'b0;
            if (coin_T) begin
              r_n_tens  <= r_n_tens - PW'(1);
              tens_left <= tens_left - CW'(1);
            end else begin
              r_n_fives  <= r_n_fives - PW'(1);
              fives_left <= fives_left - CW'(1);
            end
            r_state <= S_GAP;
          end else if (w_timeout) begin
            coin_T  <= 1'b0;
            coin_F  <= 1'b0;
            error   <= 1'b1;
            r_state <= S_ERR;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end

        // One dead cycle so the request is low for at least two cycles
        // (GAP + ISSUE) between coins.
        S_GAP: r_state <= S_ISSUE;

        S_DONE, S_ERR: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          coin_T  <= 1'b0;
          coin_F  <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fsm_change_dispenser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fsm_change_dispenser                                    |
// | Description : Directed self-checking bench for fsm_change_dispenser.     |
// |               Drives payouts, answers coin requests with hopper_ack and  |
// |               compares coin counts, timing, status pulses and inventory  |
// |               against hand-computed values.                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_fsm_change_dispenser;

  logic       clk;
  logic       reset;
  logic       start;
  logic [5:0] credit;
  logic [5:0] price;
  logic       refill;
  logic       hopper_ack;
  logic       coin_T;
  logic       coin_F;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] tens_left;
  logic [3:0] fives_left;

  int n_checks = 0;
  int n_errors = 0;

  // Per-payout observations (cycle 1 = first cycle after the start edge).
  int r_nt, r_nf, r_nd, r_ne, r_first, r_done_at, r_busy, r_both, r_maxhi, r_ended;

  fsm_change_dispenser #(
    .W(6), .INIT_TENS(4), .INIT_FIVES(4), .CW(4), .ACK_TIMEOUT(15)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .credit     (credit),
    .price      (price),
    .refill     (refill),
    .hopper_ack (hopper_ack),
    .coin_T     (coin_T),
    .coin_F     (coin_F),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .tens_left  (tens_left),
    .fives_left (fives_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; refill = 1'b0; hopper_ack = 1'b0;
    credit = '0; price = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic do_refill();
    refill = 1'b1;
    step();
    refill = 1'b0;
  endtask

  // Launch one payout and follow it until busy drops. ack_dly > 0 asserts
  // hopper_ack for one cycle on the ack_dly-th cycle a request is high;
  // ack_dly <= 0 never acks. poke drives start+refill mid-payout.
  task automatic run_payout(input int cr, input int pr, input int ack_dly,
                            input bit with_refill, input bit poke);
    int   hi;
    logic pt, pf;
    r_nt = 0; r_nf = 0; r_nd = 0; r_ne = 0; r_first = 0; r_done_at = 0;
    r_busy = 0; r_both = 0; r_maxhi = 0; r_ended = 0;
    credit = cr[5:0]; price = pr[5:0];
    start = 1'b1; refill = with_refill;
    step();
    start = 1'b0; refill = 1'b0;
    pt = 1'b0; pf = 1'b0; hi = 0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (coin_T && !pt) begin r_nt++; if (r_first == 0) r_first = cyc; end
      if (coin_F && !pf) begin r_nf++; if (r_first == 0) r_first = cyc; end
      pt = coin_T; pf = coin_F;
      if (coin_T && coin_F) r_both++;
      if (coin_T || coin_F) begin
        hi++;
        if (hi > r_maxhi) r_maxhi = hi;
      end else begin
        hi = 0;
      end
      hopper_ack = (ack_dly > 0) && (hi == ack_dly);
      if (done) begin r_nd++; r_done_at = cyc; end
      if (error) r_ne++;
      if (busy) r_busy++;
      if (poke) begin
        start  = (cyc == 5);
        refill = (cyc == 5);
        credit = 6'd20;
      end
      if (!busy) begin r_ended = 1; break; end
      step();
    end
    hopper_ack = 1'b0; start = 1'b0; refill = 1'b0;
    check("payout_ended", r_ended, 1);
    check("never_both_coins", r_both, 0);
  endtask

  task automatic wait_coin_t(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (coin_T) begin ok = 1'b1; break; end
      step();
    end
  endtask

  initial begin
    bit ok;
    reset = 1'b1; start = 1'b0; refill = 1'b0; hopper_ack = 1'b0;
    credit = '0; price = '0;

    // Reset state
    do_reset();
    check("rst_coin_T", int'(coin_T), 0);
    check("rst_coin_F", int'(coin_F), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    check("rst_tens", int'(tens_left), 4);
    check("rst_fives", int'(fives_left), 4);

    // chg = 4 -> two tens
    run_payout(7, 3, 2, 1'b0, 1'b0);
    check("p1_nT", r_nt, 2);
    check("p1_nF", r_nf, 0);
    check("p1_done", r_nd, 1);
    check("p1_err", r_ne, 0);
    check("p1_first_coin_cyc", r_first, 3);
    check("p1_tens", int'(tens_left), 2);
    check("p1_fives", int'(fives_left), 4);

    // Zero change
    run_payout(3, 3, 2, 1'b0, 1'b0);
    check("z_coins", r_nt + r_nf, 0);
    check("z_done", r_nd, 1);
    check("z_done_cyc", r_done_at, 3);
    check("z_busy_cycles", r_busy, 3);
    check("z_tens", int'(tens_left), 2);
    check("z_fives", int'(fives_left), 4);

    // Drain tens, then fall back to fives
    do_reset();
    run_payout(4, 0, 2, 1'b0, 1'b0);
    run_payout(6, 2, 2, 1'b0, 1'b0);
    check("drain_tens", int'(tens_left), 0);
    run_payout(5, 2, 2, 1'b0, 1'b0);
    check("f_nT", r_nt, 0);
    check("f_nF", r_nf, 3);
    check("f_done", r_nd, 1);
    check("f_fives", int'(fives_left), 1);

    // Start with refill: plan must use the refilled counts (else it errors)
    run_payout(7, 3, 2, 1'b1, 1'b0);
    check("sr_nT", r_nt, 2);
    check("sr_done", r_nd, 1);
    check("sr_err", r_ne, 0);
    check("sr_tens", int'(tens_left), 2);
    check("sr_fives", int'(fives_left), 4);

    // Infeasible payout: chg 20 > 2*4 + 4
    do_refill();
    run_payout(20, 0, 2, 1'b0, 1'b0);
    check("inf_err", r_ne, 1);
    check("inf_done", r_nd, 0);
    check("inf_coins", r_nt + r_nf, 0);
    check("inf_busy_cycles", r_busy, 2);
    check("inf_tens", int'(tens_left), 4);
    check("inf_fives", int'(fives_left), 4);

    // credit < price
    run_payout(1, 2, 2, 1'b0, 1'b0);
    check("short_err", r_ne, 1);
    check("short_coins", r_nt + r_nf, 0);

    // Hopper never acks -> timeout
    run_payout(4, 0, 0, 1'b0, 1'b0);
    check("to_nT", r_nt, 1);
    check("to_high_cycles", r_maxhi, 15);
    check("to_err", r_ne, 1);
    check("to_done", r_nd, 0);
    check("to_tens", int'(tens_left), 4);
    run_payout(2, 0, 2, 1'b1, 1'b0);
    check("after_to_nT", r_nt, 1);
    check("after_to_done", r_nd, 1);
    check("after_to_tens", int'(tens_left), 3);

    // start/refill while busy are ignored
    do_reset();
    run_payout(4, 0, 2, 1'b0, 1'b1);
    check("poke_nT", r_nt, 2);
    check("poke_done", r_nd, 1);
    check("poke_tens", int'(tens_left), 2);
    step();
    step();
    check("poke_no_restart", int'(busy), 0);

    // hopper_ack in IDLE is ignored
    hopper_ack = 1'b1;
    step();
    step();
    hopper_ack = 1'b0;
    check("idle_ack_tens", int'(tens_left), 2);
    check("idle_ack_fives", int'(fives_left), 4);

    // Reset during WAIT of the second coin
    do_reset();
    credit = 6'd4; price = 6'd0; start = 1'b1;
    step();
    start = 1'b0;
    wait_coin_t(ok);
    check("mid_c1_seen", int'(ok), 1);
    step();
    hopper_ack = 1'b1;
    step();
    hopper_ack = 1'b0;
    check("mid_c1_dropped", int'(coin_T), 0);
    check("mid_tens_after_c1", int'(tens_left), 3);
    wait_coin_t(ok);
    check("mid_c2_seen", int'(ok), 1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_coin_T", int'(coin_T), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_tens", int'(tens_left), 4);
    check("mid_rst_fives", int'(fives_left), 4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fsm_change_dispenser.md
Name: fsm_change_dispenser

Overview:
- Return-path counterpart to the coin-accepting vending FSM: that FSM consumes coin_T/coin_F pulses, this block generates them toward the coin hopper to pay out change.
- On start, computes change = credit - price in 5-unit coins and plans a payout, tens first, falling back to fives when ten-coins run out.
- Drives a held-request/ack handshake to the hopper per coin, tracks coin inventory, and flags infeasible payouts and hopper jams.

Parameters:
- W, 6, width of credit/price/change in units of 5 (1 unit = one F coin, 2 units = one T coin)
- INIT_TENS, 4, ten-coin inventory after reset/refill
- INIT_FIVES, 4, five-coin inventory after reset/refill
- CW, 4, inventory counter width
- ACK_TIMEOUT, 15, max cycles a coin request may wait for hopper_ack

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high
- start  input  1  single-cycle request to pay change; sampled only in IDLE
- credit  input  W  inserted amount in units of 5, sampled with start
- price  input  W  item price in units of 5, sampled with start
- refill  input  1  reload both inventories to INIT_*; honoured only in IDLE
- hopper_ack  input  1  hopper has released the requested coin
- coin_T  output  1  request hopper to release one ten-coin; held until ack
- coin_F  output  1  request hopper to release one five-coin; held until ack
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse, payout complete
- error  output  1  one-cycle pulse, payout refused or aborted
- tens_left  output  CW  current ten-coin inventory
- fives_left  output  CW  current five-coin inventory

Behaviour:
- Reset: state IDLE; coin_T=coin_F=busy=done=error=0; tens_left=INIT_TENS; fives_left=INIT_FIVES; plan counters and timer 0. Reset wins over all inputs, including mid-payout. An in-flight request drops next cycle with no inventory change.
- All outputs are registered. coin_T and coin_F are never high together.
- States: IDLE, CHECK, ISSUE, WAIT, GAP, DONE, ERR.
- IDLE:
  - refill reloads inventories.
  - start latches credit and price and goes to CHECK.
  - start and refill in the same cycle: refill applied, start also accepted, and CHECK uses the refilled counts.
  - start outside IDLE is ignored.
- CHECK (1 cycle):
  - If credit < price, go to ERR.
  - Otherwise chg = credit - price, computed at W bits with no wrap.
  - nT = min(chg>>1, tens_left); nF = chg - 2*nT.
  - If nF > fives_left, go to ERR. Else go to ISSUE.
  - Inventory is untouched.
- ISSUE (1 cycle):
  - If nT > 0, set coin_T.
  - Else if nF > 0, set coin_F.
  - Else go to DONE.
  - After setting a coin, go to WAIT and clear the timer.
  - First coin rises 3 cycles after the start sample edge.
- WAIT:
  - Request is held. Timer increments each cycle.
  - On hopper_ack: drop the request next cycle; decrement nT and tens_left (T) or nF and fives_left (F); go to GAP.
  - If the timer reaches ACK_TIMEOUT without ack: drop the request, go to ERR, leave inventory unchanged.
- GAP (1 cycle): request low, ignore hopper_ack, go to ISSUE. This guarantees at least 2 low cycles between coins.
- hopper_ack outside WAIT is ignored.
- DONE: done=1 for 1 cycle, then IDLE.
- ERR: error=1 for 1 cycle, then IDLE. Coins already paid stay deducted.
- Zero change (credit == price): done pulses 3 cycles after start with no coin activity.

Test Plan:
- Reset, credit=7, price=3, ack 2 cycles after each request -> two coin_T pulses, no coin_F, done=1 once, tens_left=2, fives_left=4.
- credit=3, price=3 -> no coins, done 3 cycles after start, busy high for 3 cycles, inventories unchanged.
- Drain tens to 0 via two payouts of chg=4, then credit=5, price=2 -> three coin_F pulses, done, fives_left=1.
- credit=20, price=0 (chg 20 > 2*4+4) -> error pulse from CHECK, no coin activity, inventory 4/4. Separately credit=1, price=2 -> error.
- credit=4, price=0, hopper_ack never asserted -> coin_T high exactly ACK_TIMEOUT cycles, then error, tens_left stays 4. Then refill and start credit=2, price=0 -> one coin_T, done.
- Reset asserted during WAIT of the second coin of a chg=4 payout -> next cycle coin_T=0, busy=0, tens_left=INIT_TENS. Also: start while busy is ignored, and refill while busy leaves inventory unchanged.
